// File: rtl/digit_scan_sequencer.sv
// Time-multiplexed scan sequencer: steps a 3-bit position code through the enabled
// positions of an 8-entry matrix, with a blanking window per slot and a frame pulse.
module digit_scan_sequencer #(
  parameter int unsigned PRESCALE = 1000,
  parameter int unsigned BLANK    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [7:0]  digit_mask,
  input  logic        load,
  input  logic [31:0] digits_in,
  output logic [2:0]  code_out,
  output logic [3:0]  seg_data,
  output logic        blank,
  output logic        frame_done
);

  typedef enum logic [1:0] {IDLE, BLANKING, SHOW} state_e;

  localparam logic [15:0] PRE_LAST   = 16'(PRESCALE - 1);
  localparam logic [15:0] BLANK_LAST = 16'(BLANK - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  code_q, code_d;
  logic [3:0]  seg_q, seg_d;
  logic        blank_q, blank_d;
  logic        frame_done_q, frame_done_d;
  logic [31:0] pending_q, pending_d;
  logic [31:0] active_q, active_d;
  logic [2:0]  nxt_idx, first_idx;
  logic        scan_ok;

  // First set mask bit strictly after cur, wrapping; returns cur itself when it is the only one.
  function automatic logic [2:0] next_idx(input logic [7:0] mask, input logic [2:0] cur);
    logic [2:0] idx;
    logic [2:0] cand;
    logic       found;
    idx   = cur;
    found = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      cand = cur + 3'(k);
      if (!found && mask[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

  function automatic logic [3:0] nibble(input logic [31:0] d, input logic [2:0] i);
    return d[{i, 2'b00} +: 4];
  endfunction

  assign nxt_idx   = next_idx(digit_mask, code_q);
  assign first_idx = next_idx(digit_mask, 3'd7);
  assign scan_ok   = en && (digit_mask != 8'h00);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    code_d       = code_q;
    seg_d        = seg_q;
    frame_done_d = 1'b0;
    pending_d    = load ? digits_in : pending_q;
    active_d     = active_q;

    case (state_q)
      IDLE: begin
        if (scan_ok) begin
          state_d  = BLANKING;
          cnt_d    = '0;
          code_d   = first_idx;
          active_d = pending_d;
          seg_d    = nibble(pending_d, first_idx);
        end
      end
      BLANKING: begin
        if (!scan_ok) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_q == BLANK_LAST) state_d = SHOW;
        end
      end
      SHOW: begin
        if (!scan_ok) begin
          state_d = IDLE;
        end else if (cnt_q == PRE_LAST) begin
          state_d = BLANKING;
          cnt_d   = '0;
          code_d  = nxt_idx;
          // Wrap or single position closes the frame; swap in the pending digits here only.
          if (nxt_idx <= code_q) begin
            frame_done_d = 1'b1;
            active_d     = pending_d;
            seg_d        = nibble(pending_d, nxt_idx);
          end else begin
            seg_d = nibble(active_q, nxt_idx);
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    blank_d = (state_d != SHOW);
  end

  // NOTE: reset is sampled on the clock edge, and state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      code_q       <= '0;
      seg_q        <= '0;
      blank_q      <= 1'b1;
      frame_done_q <= 1'b0;
      pending_q    <= '0;
      active_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      code_q       <= code_d;
      seg_q        <= seg_d;
      blank_q      <= blank_d;
      frame_done_q <= frame_done_d;
      pending_q    <= pending_d;
      active_q     <= active_d;
    end
  end

  assign code_out   = code_q;
  assign seg_data   = seg_q;
  assign blank      = blank_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_digit_scan_sequencer.sv
// Scoreboard bench for digit_scan_sequencer: a slot-level model predicts every cycle's
// outputs into a queue, and a monitor on the falling edge pops and compares.
module tb_digit_scan_sequencer;

  localparam int PRESCALE = 8;
  localparam int BLANK    = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [7:0]  digit_mask;
  logic        load;
  logic [31:0] digits_in;
  logic [2:0]  code_out;
  logic [3:0]  seg_data;
  logic        blank;
  logic        frame_done;

  digit_scan_sequencer #(.PRESCALE(PRESCALE), .BLANK(BLANK)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .digit_mask (digit_mask),
    .load       (load),
    .digits_in  (digits_in),
    .code_out   (code_out),
    .seg_data   (seg_data),
    .blank      (blank),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] code;
    logic [3:0] seg;
    logic       blank;
    logic       fd;
  } obs_t;

  obs_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   stop_mon = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Reference model: a running flag, a position and a phase within the slot.
  bit         m_run;
  int         m_pos;
  int         m_phase;
  logic [3:0] m_pend[8];
  logic [3:0] m_disp[8];
  obs_t       m_out;

  always @(posedge clk) begin
    logic [3:0] newpend[8];
    int         nxt;
    obs_t       o;
    cyc++;
    for (int i = 0; i < 8; i++) newpend[i] = load ? digits_in[4*i +: 4] : m_pend[i];
    o    = m_out;
    o.fd = 1'b0;
    if (!rst_n) begin
      m_run = 1'b0;
      o     = '{code: 3'd0, seg: 4'd0, blank: 1'b1, fd: 1'b0};
      for (int i = 0; i < 8; i++) begin
        newpend[i] = 4'd0;
        m_disp[i]  = 4'd0;
      end
    end else if (!m_run) begin
      if (en && digit_mask != 8'h00) begin
        m_run   = 1'b1;
        m_phase = 0;
        m_pos   = -1;
        for (int i = 7; i >= 0; i--) if (digit_mask[i]) m_pos = i;
        for (int i = 0; i < 8; i++) m_disp[i] = newpend[i];
        o.code = 3'(m_pos);
        o.seg  = m_disp[m_pos];
      end
    end else if (!en || digit_mask == 8'h00) begin
      m_run = 1'b0;
    end else begin
      m_phase++;
      if (m_phase == PRESCALE) begin
        m_phase = 0;
        nxt     = -1;
        for (int k = 8; k >= 1; k--) if (digit_mask[(m_pos + k) % 8]) nxt = (m_pos + k) % 8;
        if (nxt <= m_pos) begin
          o.fd = 1'b1;
          for (int i = 0; i < 8; i++) m_disp[i] = newpend[i];
        end
        m_pos  = nxt;
        o.code = 3'(m_pos);
        o.seg  = m_disp[m_pos];
      end
    end
    o.blank = !m_run || (m_phase < BLANK);
    for (int i = 0; i < 8; i++) m_pend[i] = newpend[i];
    m_out = o;
    exp_q.push_back(o);
  end

  // Monitor: one comparison per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    obs_t got, req;
    if (!stop_mon && exp_q.size() > 0) begin
      req = exp_q.pop_front();
      got = '{code: code_out, seg: seg_data, blank: blank, fd: frame_done};
      check($sformatf("cycle%0d code/seg/blank/fd", cyc), 32'(got), 32'(req));
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe_load(input logic [31:0] d);
    digits_in = d;
    load      = 1'b1;
    tick(1);
    load      = 1'b0;
  endtask

  task automatic wait_show(input logic [2:0] pos, input string name);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 300 && !hit; i++) begin
      if (code_out == pos && !blank) hit = 1'b1;
      else tick(1);
    end
    check({name, " reached"}, 32'(hit), 32'd1);
  endtask

  initial begin
    rst_n      = 1'b0;
    en         = 1'b0;
    digit_mask = 8'h00;
    load       = 1'b0;
    digits_in  = 32'h0;
    tick(3);
    rst_n = 1'b1;

    // Full mask, identity digits.
    strobe_load(32'h76543210);
    digit_mask = 8'hFF;
    en         = 1'b1;
    tick(140);

    // Sparse mask.
    digit_mask = 8'b1010_0100;
    strobe_load(32'h87654321);
    tick(80);

    // Load mid-frame while showing position 3.
    digit_mask = 8'hFF;
    tick(20);
    wait_show(3'd3, "show pos3");
    tick(2);
    strobe_load(32'hAAAAAAAA);
    tick(100);

    // Single position.
    digit_mask = 8'h10;
    tick(40);

    // Enable drop mid-SHOW, re-enable, then mask to zero.
    digit_mask = 8'hFF;
    strobe_load($urandom);
    wait_show(3'd2, "show pos2");
    en = 1'b0;
    tick(4);
    en = 1'b1;
    tick(30);
    digit_mask = 8'h00;
    tick(4);
    digit_mask = 8'b0110_1000;
    tick(40);

    // Reset during SHOW of position 5, then scan the cleared digits.
    digit_mask = 8'hFF;
    wait_show(3'd5, "show pos5");
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(40);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      en    = ($urandom_range(0, 39) != 0);
      rst_n = ($urandom_range(0, 399) != 0);
      load  = ($urandom_range(0, 9) == 0);
      digits_in = $urandom;
      if ($urandom_range(0, 29) == 0)
        digit_mask = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      tick(1);
    end
    load = 1'b0;
    tick(3);

    @(negedge clk);
    #1;
    stop_mon = 1'b1;
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/digit_scan_sequencer.md
# digit_scan_sequencer

Time-multiplexed scan sequencer for an 8-position display or keypad matrix. It sits directly upstream of the 3-to-8 one-hot select decoder and drives that decoder's 3-bit code input. It steps through the enabled positions at a programmable slot rate and presents the matching 4-bit digit nibble. A blanking window at the start of each slot suppresses ghosting, and the sequencer flags each completed frame.

## Interface
Parameters:
- PRESCALE, default 1000: clock cycles per scan slot; legal range 2..65535.
- BLANK, default 16: cycles at the start of each slot with blank asserted; legal range 1..PRESCALE-1.

Ports:
- clk  input  1  sole clock; all state changes on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- en  input  1  scan enable; level-sensitive.
- digit_mask  input  8  bit i=1 means position i takes part in the scan.
- load  input  1  one-cycle strobe; captures digits_in into the pending frame.
- digits_in  input  32  nibble i at [4i+3:4i] is the digit for position i.
- code_out  output  3  position select, fed to the 3-to-8 decoder.
- seg_data  output  4  digit nibble for the current position.
- blank  output  1  1 means downstream drivers must be suppressed.
- frame_done  output  1  one-cycle pulse at the end of the last enabled slot of a frame.

## Operation
- Registers:
  - pending[31:0] receives new digits.
  - active[31:0] holds the digits being displayed.
  - slot counter is 16 bits wide.
  - state is one of IDLE, BLANKING, SHOW.
- Reset (rst_n=0 at an edge) sets code_out=0, seg_data=0, blank=1, frame_done=0, pending=0, active=0, counter=0 and state=IDLE. Reset wins over every other input and aborts any slot in progress.
- load=1 at an edge captures digits_in into pending. active changes only at a frame boundary, so a frame never tears.
- IDLE:
  - blank=1.
  - If en=1 and digit_mask≠0, the block goes to BLANKING.
  - On that entry, code_out is set to the lowest set mask bit.
  - active takes digits_in if load=1 that cycle, otherwise pending.
  - counter is cleared.
- BLANKING: blank=1; counter increments. When counter=BLANK-1, the block goes to SHOW.
- SHOW:
  - blank=0; counter increments.
  - When counter=PRESCALE-1 (the slot end), the next index is chosen from the current digit_mask.
  - The search runs circularly from code_out+1 and takes the first set bit.
  - If the current bit is the only set bit, the next index equals code_out.
- Slot end, general:
  - counter clears, the state returns to BLANKING, and code_out takes the next index.
  - seg_data takes the nibble from active for the new index.
- Slot end, frame boundary: a frame boundary is a slot end where next index ≤ code_out (wrap or single position). At a frame boundary:
  - frame_done=1 for exactly that cycle.
  - active takes digits_in if load=1 that cycle, otherwise pending.
  - seg_data uses the updated active.
- Mask and enable events:
  - If digit_mask becomes 0 or en falls, the block enters IDLE at the next edge with blank=1. code_out and seg_data hold their last values. No frame_done is issued.
  - A mask change mid-slot does not shorten the current slot; it takes effect at the slot end.
- seg_data is constant for the whole slot, including the blanking window.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Start-up: en rises at edge E with the mask nonzero.
  - At E+1, BLANKING begins with code_out valid.
  - blank falls at E+1+BLANK.
- Each slot is exactly PRESCALE cycles long: BLANK cycles blanked, then PRESCALE-BLANK cycles shown.
- A frame of N enabled positions lasts N×PRESCALE cycles. frame_done fires once per frame, in the cycle after the last SHOW cycle.
- load affects the display at the first frame boundary at or after the strobe, never earlier.

## Test plan
Bench parameters: PRESCALE=8, BLANK=2.
1. Reset then en=1, mask=8'hFF, with digits_in=32'h76543210 and load=1 before en. Required:
   - code_out steps 0,1,…,7,0 with 8 cycles per slot.
   - seg_data equals code_out in every slot.
   - blank is high for 2 cycles per slot.
   - frame_done pulses once every 64 cycles, coincident with the 7→0 transition.
2. mask=8'b10100100, digits=32'h87654321. Required: code_out sequence 2,5,7,2,…; seg_data sequence 3,6,8; frame_done every 24 cycles.
3. load 32'hAAAAAAAA mid-frame while the scan shows position 3. Required: seg_data keeps the old values until the 7→0 boundary, then shows A for every position.
4. Single position, mask=8'h10. Required: code_out stays 4; frame_done pulses every 8 cycles; blank pattern is 2 high, 6 low.
5. Mid-slot events:
   - Drop en in the middle of a SHOW window: next edge gives blank=1, IDLE, and no frame_done.
   - Re-enable: scanning restarts from the lowest set mask bit.
   - Set mask=0 while enabled: same result as dropping en.
6. Assert rst_n=0 for one cycle during SHOW of position 5. Required: next edge gives code_out=0, seg_data=0, blank=1, frame_done=0, and pending and active cleared.
